// File: rtl/uart_dbg_pkg.sv
// Shared state type and constants for the UART debug bus master.
// Define UART_DBG_CHECKSUM_EN to add the trailing XOR checksum state.
package uart_dbg_pkg;

   localparam logic [3:0] OP_WRITE    = 4'hA;
   localparam logic [3:0] OP_READ     = 4'h5;
   localparam logic [7:0] ACK_DEFAULT = 8'h06;
   localparam logic [7:0] NAK_DEFAULT = 8'h15;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
`ifdef UART_DBG_CHECKSUM_EN
      StCsum,
`endif
      StReq,
      StWait,
      StResp
   } state_e;

endpackage

// File: rtl/uart_dbg_master_if.sv
// UART byte stream and memory bus signals seen by the debug master.
interface uart_dbg_master_if;

   logic [7:0]  rx_data;
   logic        new_rx_data;
   logic [7:0]  tx_data;
   logic        new_tx_data;
   logic        tx_busy;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   modport master (
      input  rx_data, new_rx_data, tx_busy, mem_rdata, mem_resp,
      output tx_data, new_tx_data, mem_addr, mem_rmask, mem_wmask, mem_wdata
   );

   modport slave (
      output rx_data, new_rx_data, tx_busy, mem_rdata, mem_resp,
      input  tx_data, new_tx_data, mem_addr, mem_rmask, mem_wmask, mem_wdata
   );

endinterface

// File: rtl/uart_dbg_resp_ser.sv
// Response serializer: up to five queued bytes, head byte sent first, one
// strobe per byte, paced by tx_busy and never on two consecutive cycles.
module uart_dbg_resp_ser (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [4:0][7:0] load_bytes,
   input  logic [2:0]      load_cnt,
   input  logic            tx_busy,
   output logic [7:0]      tx_data,
   output logic            new_tx_data,
   output logic            done
);

   logic [4:0][7:0] q_q, q_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            sent_q;
   logic            send;

   // tx_busy rises a cycle after a strobe, so the previous-pulse guard covers that gap.
   always_comb begin
      send  = (cnt_q != 3'd0) && !tx_busy && !sent_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load) begin
         q_d   = load_bytes;
         cnt_d = load_cnt;
      end else if (send) begin
         q_d   = {8'h00, q_q[4:1]};
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= '0;
         cnt_q  <= '0;
         sent_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         sent_q <= send;
      end
   end

   assign tx_data     = q_q[0];
   assign new_tx_data = send;
   assign done        = (cnt_q == 3'd0);

endmodule

// File: rtl/uart_dbg_master.sv
// UART-driven memory bus initiator: host frames become single bus transactions,
// answered with ACK (+ read data) or NAK. UART_DBG_CHECKSUM_EN adds a checksum byte.
module uart_dbg_master
   import uart_dbg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
   parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_dbg_master_if.master        bus,
   output logic                     busy
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

   state_e          state_q, state_d, end_state;
   logic [7:0]      cmd_q, cmd_d;
   logic [1:0]      idx_q, idx_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            is_write, load_nak;
   logic            ld, ser_done;
   logic [4:0][7:0] ld_bytes;
   logic [2:0]      ld_cnt;
`ifdef UART_DBG_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   assign is_write = (cmd_q[7:4] == OP_WRITE);

   always_comb begin
`ifdef UART_DBG_CHECKSUM_EN
      end_state = StCsum;
`else
      end_state = (cmd_q[3:0] == 4'h0) ? StResp : StReq;
`endif
   end

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      tmo_d    = tmo_q;
      load_nak = 1'b0;
      ld       = 1'b0;
      ld_bytes = '0;
      ld_cnt   = 3'd0;
`ifdef UART_DBG_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.new_rx_data) begin
               cmd_d = bus.rx_data;
               idx_d = 2'd0;
`ifdef UART_DBG_CHECKSUM_EN
               csum_d = bus.rx_data;
`endif
               if (bus.rx_data[7:4] == OP_WRITE || bus.rx_data[7:4] == OP_READ) begin
                  state_d = StAddr;
               end else begin
                  load_nak = 1'b1;
                  state_d  = StResp;
               end
            end
         end
         StAddr, StData: begin
            if (bus.new_rx_data) begin
               if (state_q == StAddr) addr_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
               else                   wdata_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
               idx_d = idx_q + 2'd1;
`ifdef UART_DBG_CHECKSUM_EN
               csum_d = csum_q ^ bus.rx_data;
`endif
               if (idx_q == 2'd3) begin
                  if (state_q == StAddr && is_write) begin
                     state_d = StData;
                  end else begin
                     state_d  = end_state;
                     load_nak = (end_state == StResp);
                  end
               end
            end
         end
`ifdef UART_DBG_CHECKSUM_EN
         StCsum: begin
            if (bus.new_rx_data) begin
               if (bus.rx_data == csum_q && cmd_q[3:0] != 4'h0) begin
                  state_d = StReq;
               end else begin
                  load_nak = 1'b1;
                  state_d  = StResp;
               end
            end
         end
`endif
         StReq: begin
            state_d = StWait;
            tmo_d   = '0;
         end
         StWait: begin
            // A response arriving on the final timeout cycle still counts.
            if (bus.mem_resp) begin
               ld       = 1'b1;
               ld_bytes = {bus.mem_rdata, ACK_BYTE};
               ld_cnt   = is_write ? 3'd1 : 3'd5;
               state_d  = StResp;
            end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
               load_nak = 1'b1;
               state_d  = StResp;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StResp: begin
            if (ser_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (load_nak) begin
         ld          = 1'b1;
         ld_bytes[0] = NAK_BYTE;
         ld_cnt      = 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cmd_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         tmo_q   <= '0;
`ifdef UART_DBG_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         tmo_q   <= tmo_d;
`ifdef UART_DBG_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   uart_dbg_resp_ser u_ser (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (ld),
      .load_bytes  (ld_bytes),
      .load_cnt    (ld_cnt),
      .tx_busy     (bus.tx_busy),
      .tx_data     (bus.tx_data),
      .new_tx_data (bus.new_tx_data),
      .done        (ser_done)
   );

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_rmask = (state_q == StReq && !is_write) ? cmd_q[3:0] : 4'h0;
   assign bus.mem_wmask = (state_q == StReq &&  is_write) ? cmd_q[3:0] : 4'h0;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_dbg_master.sv
// Self-checking bench for uart_dbg_master: frame-level model plus per-cycle monitors.
module tb_uart_dbg_master;

   localparam int unsigned TMO = 16;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      bit          wr;
   } req_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   uart_dbg_master_if bus ();

   uart_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   logic [7:0]  exp_tx[$];
   req_t        exp_req[$];
   logic [7:0]  tx_log[$];
   bit          resp_en = 1'b1;
   int          resp_delay = 3;
   logic [31:0] resp_rdata = '0;
   int          resp_due = -1;
   bit          stray_resp = 1'b0;
   int          busy_len = 4;
   int          busy_left = 0;
   int          req_cyc = 0, resp_cyc = 0, last_rx_cyc = 0, last_tx_cyc = 0;
   req_t        cur_req;
   bit          prev_pulse = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Frame-level model: what a host frame must produce on the bus and on tx.
   task automatic model_frame(input logic [7:0] f[$]);
      logic [3:0] op, mask;
      bit         good;
      req_t       r;
      op   = f[0][7:4];
      mask = f[0][3:0];
      if (op != 4'hA && op != 4'h5) begin
         exp_tx.push_back(8'h15);
         return;
      end
      r.wr    = (op == 4'hA);
      r.addr  = {f[4], f[3], f[2], f[1]};
      r.wdata = r.wr ? {f[8], f[7], f[6], f[5]} : 32'h0;
      r.rmask = r.wr ? 4'h0 : mask;
      r.wmask = r.wr ? mask : 4'h0;
      good    = (mask != 4'h0);
`ifdef UART_DBG_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'h00;
         for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
         if (x != f[f.size()-1]) good = 1'b0;
      end
`endif
      if (!good) begin
         exp_tx.push_back(8'h15);
         return;
      end
      exp_req.push_back(r);
      if (!resp_en) begin
         exp_tx.push_back(8'h15);
      end else begin
         exp_tx.push_back(8'h06);
         if (!r.wr) for (int i = 0; i < 4; i++) exp_tx.push_back(resp_rdata[8*i +: 8]);
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data     = b;
      bus.new_rx_data = 1'b1;
      last_rx_cyc     = cyc;
      @(posedge clk); #1;
      bus.new_rx_data = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] fr[$], input logic [7:0] flip);
`ifdef UART_DBG_CHECKSUM_EN
      if (fr[0][7:4] == 4'hA || fr[0][7:4] == 4'h5) begin
         logic [7:0] x;
         x = 8'h00;
         foreach (fr[i]) x ^= fr[i];
         fr.push_back(x ^ flip);
      end
`else
      if (flip != 8'h00) $display("note: checksum flip ignored in this build");
`endif
      model_frame(fr);
      foreach (fr[i]) strobe(fr[i]);
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy && exp_tx.size() == 0 && exp_req.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_done"}, {63'd0, ok}, 64'd1);
   endtask

   // Bus monitor: every request cycle must match the next modelled request.
   initial forever begin
      @(negedge clk);
      if (rst_n && (bus.mem_rmask != 4'h0 || bus.mem_wmask != 4'h0)) begin
         check("req_expected", {63'd0, exp_req.size() != 0}, 64'd1);
         if (exp_req.size() != 0) begin
            cur_req = exp_req.pop_front();
            req_cyc = cyc;
            check("req_rmask", {60'd0, bus.mem_rmask}, {60'd0, cur_req.rmask});
            check("req_wmask", {60'd0, bus.mem_wmask}, {60'd0, cur_req.wmask});
            check("req_addr", {32'd0, bus.mem_addr}, {32'd0, cur_req.addr});
            if (cur_req.wr) check("req_wdata", {32'd0, bus.mem_wdata}, {32'd0, cur_req.wdata});
            resp_due = resp_en ? cyc + resp_delay : -1;
         end
      end
      if (rst_n && bus.mem_resp && !stray_resp && resp_cyc == cyc) begin
         check("addr_stable", {32'd0, bus.mem_addr}, {32'd0, cur_req.addr});
         if (cur_req.wr) check("wdata_stable", {32'd0, bus.mem_wdata}, {32'd0, cur_req.wdata});
      end
   end

   // Tx monitor: pacing rules and byte order against the model queue.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_pulse = 1'b0;
      end else begin
         if (bus.new_tx_data) begin
            check("tx_not_busy", {63'd0, bus.tx_busy}, 64'd0);
            check("tx_no_b2b", {63'd0, prev_pulse}, 64'd0);
            check("tx_expected", {63'd0, exp_tx.size() != 0}, 64'd1);
            if (exp_tx.size() != 0) check("tx_byte", {56'd0, bus.tx_data}, {56'd0, exp_tx.pop_front()});
            tx_log.push_back(bus.tx_data);
            last_tx_cyc = cyc;
            busy_left   = busy_len;
         end
         prev_pulse = bus.new_tx_data;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      bus.tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
   end

   initial forever begin
      @(posedge clk); #1;
      bus.mem_resp = 1'b0;
      if (resp_due >= 0 && cyc == resp_due) begin
         bus.mem_resp  = 1'b1;
         bus.mem_rdata = resp_rdata;
         resp_cyc      = cyc;
         resp_due      = -1;
      end
      if (stray_resp) begin
         bus.mem_resp = 1'b1;
         stray_resp   = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fr[$];
      logic [7:0] exp_rd [5];
      int n;
      bus.rx_data     = 8'h00;
      bus.new_rx_data = 1'b0;
      bus.tx_busy     = 1'b0;
      bus.mem_rdata   = 32'h0;
      bus.mem_resp    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_tx_data", {56'd0, bus.tx_data}, 64'd0);
      check("rst_new_tx", {63'd0, bus.new_tx_data}, 64'd0);
      check("rst_addr", {32'd0, bus.mem_addr}, 64'd0);
      check("rst_masks", {56'd0, bus.mem_rmask, bus.mem_wmask}, 64'd0);
      check("rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Write, response 3 cycles after the request.
      resp_en = 1'b1; resp_delay = 3; busy_len = 4;
      fr = '{8'hAF, 8'h00, 8'h10, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame(fr, 8'h00);
      wait_done("write");
      check("write_req_latency", 64'(req_cyc - last_rx_cyc), 64'd1);
      check("write_ack_latency", 64'(last_tx_cyc - resp_cyc), 64'd1);
      check("write_lit_addr", {32'd0, cur_req.addr}, 64'h8000_1000);
      check("write_lit_tx", {56'd0, tx_log[tx_log.size()-1]}, 64'h06);

      // Read, paced by tx_busy.
      resp_rdata = 32'h1234_5678;
      fr = '{8'h5F, 8'h04, 8'h00, 8'h00, 8'h80};
      run_frame(fr, 8'h00);
      wait_done("read");
      exp_rd = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12};
      n = tx_log.size();
      for (int i = 0; i < 5; i++) check("read_lit_tx", {56'd0, tx_log[n-5+i]}, {56'd0, exp_rd[i]});
      check("read_lit_addr", {32'd0, cur_req.addr}, 64'h8000_0004);

      // Timeout, then a normal read with tx_busy never asserted.
      resp_en = 1'b0; busy_len = 0;
      fr = '{8'h5F, 8'h00, 8'h00, 8'h00, 8'h10};
      run_frame(fr, 8'h00);
      wait_done("timeout");
      check("timeout_nak_cycle", 64'(last_tx_cyc - req_cyc), 64'(TMO + 1));
      check("timeout_nak_lit", {56'd0, tx_log[tx_log.size()-1]}, 64'h15);
      resp_en = 1'b1; resp_rdata = 32'hA5A5_0F0F;
      fr = '{8'h53, 8'h20, 8'h00, 8'h00, 8'h10};
      run_frame(fr, 8'h00);
      wait_done("after_timeout");

      // Bad opcode, then zero-mask write.
      fr = '{8'h3F};
      run_frame(fr, 8'h00);
      wait_done("bad_op");
      fr = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(fr, 8'h00);
      wait_done("zero_mask");

      // Strobes during WAIT and RESP must be dropped.
      busy_len = 4; resp_delay = 8; resp_rdata = 32'hCAFE_F00D;
      fr = '{8'h5C, 8'h40, 8'h00, 8'h00, 8'h80};
      run_frame(fr, 8'h00);
      repeat (2) @(posedge clk);
      strobe(8'h5F);
      n = 0;
      while (!bus.new_tx_data && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("interf_resp_seen", {63'd0, bus.new_tx_data}, 64'd1);
      strobe(8'h3F);
      wait_done("interference");

      // Reset while waiting for the response.
      resp_en = 1'b0; resp_delay = 3;
      fr = '{8'hA3, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
      run_frame(fr, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_tx.delete();
      exp_req.delete();
      @(negedge clk);
      check("mid_rst_tx", {55'd0, bus.tx_data, bus.new_tx_data}, 64'd0);
      check("mid_rst_addr", {32'd0, bus.mem_addr}, 64'd0);
      check("mid_rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
      check("mid_rst_masks", {56'd0, bus.mem_rmask, bus.mem_wmask}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray_resp = 1'b1;
      repeat (5) @(negedge clk);
      check("stray_resp_idle", {63'd0, busy}, 64'd0);
      resp_en = 1'b1;
      run_frame(fr, 8'h00);
      wait_done("post_reset");

`ifdef UART_DBG_CHECKSUM_EN
      fr = '{8'hAF, 8'h00, 8'h10, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame(fr, 8'h00);
      wait_done("csum_good");
      check("csum_good_lit", {56'd0, tx_log[tx_log.size()-1]}, 64'h06);
      run_frame(fr, 8'h01);
      wait_done("csum_bad");
      check("csum_bad_lit", {56'd0, tx_log[tx_log.size()-1]}, 64'h15);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_dbg_master.md
Name: uart_dbg_master

Overview:
- UART-driven memory-bus initiator (debug/boot loader) that turns host byte frames into single memory transactions.
- Sits on the uart_top byte interface (rx_data/new_rx_data, tx_data/new_tx_data/tx_busy) and drives the same mem_* bus that the UART peripheral and other slaves respond on.
- Returns an ACK, read data, or a NAK to the host.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for mem_resp after the request before aborting with NAK. Must be ≥ 2.
- ACK_BYTE, 8'h06: success status byte.
- NAK_BYTE, 8'h15: failure status byte.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from uart_top.
- new_rx_data  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- new_tx_data  out  1  one-cycle transmit strobe.
- tx_busy  in  1  uart_top transmitter busy.
- mem_addr  out  32  request address.
- mem_rmask  out  4  read byte mask.
- mem_wmask  out  4  write byte mask.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_resp.
- mem_resp  in  1  one-cycle response strobe.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: tx_data=0, new_tx_data=0, mem_addr=0, mem_rmask=0, mem_wmask=0, mem_wdata=0, busy=0.
  - State IDLE; all counters 0.
- Frame format (all multi-byte fields LSB first):
  - CMD byte: [7:4] opcode (4'hA = write, 4'h5 = read); [3:0] byte mask.
  - ADDR: 4 bytes.
  - DATA: 4 bytes, write only.
- States: IDLE, ADDR, DATA, REQ, WAIT, RESP.
- IDLE:
  - On new_rx_data, latch the CMD byte.
  - Valid opcode: go to ADDR, byte index = 0.
  - Invalid opcode: queue NAK and go to RESP.
- ADDR: each strobe writes rx_data into address byte[idx]. After the 4th byte, a write goes to DATA and a read goes to REQ.
- DATA: same byte loading into wdata. After the 4th byte, go to REQ.
- Zero mask: when CMD mask == 0, the frame is still fully consumed, then NAK is sent; no bus request is issued.
- REQ: drive mem_rmask or mem_wmask = mask for exactly one cycle, then go to WAIT.
- mem_addr and mem_wdata stay stable from the REQ cycle until the transaction leaves WAIT.
- WAIT, timeout counter starts at 0:
  - mem_resp ends the transaction. Read: capture mem_rdata and queue ACK followed by 4 data bytes (LSB first). Write: queue ACK.
  - Counter reaching TIMEOUT_CYCLES-1 without mem_resp: queue NAK.
  - mem_resp in the same cycle as timeout: mem_resp wins.
- RESP (sends the queued bytes):
  - new_tx_data pulses only when tx_busy=0 and no pulse occurred in the previous cycle.
  - tx_data holds the byte until the pulse.
  - After the last byte, return to IDLE.
- Byte drops:
  - new_rx_data in REQ, WAIT, or RESP: byte dropped.
  - mem_resp outside WAIT: ignored.
- Latency: the REQ pulse occurs 1 cycle after the final frame byte's strobe; ACK is queued 1 cycle after mem_resp.
- Reset mid-frame or mid-transaction aborts immediately, with no response sent. Any stray mem_resp after reset is ignored.

Optional Feature:
- Macro UART_DBG_CHECKSUM_EN.
- When defined:
  - Every frame carries one extra trailing byte equal to the XOR of all preceding frame bytes (CMD included).
  - State CSUM is inserted after ADDR (read) or DATA (write).
  - A mismatch sends NAK with no bus request.
- When undefined: no CSUM state and no checksum byte.

Decomposition:
- Package uart_dbg_pkg:
  - state enum;
  - opcode constants OP_WRITE=4'hA and OP_READ=4'h5;
  - default ACK/NAK values.
- One sub-module, uart_dbg_resp_ser:
  - 5-entry byte shift queue plus count;
  - tx_busy-gated new_tx_data pulse generator with the back-to-back guard;
  - load port and done flag.

Test Plan:
- Write: bytes A F, 00 10 00 80, EF BE AD DE; responder gives mem_resp 3 cycles after the request → one-cycle mem_wmask=4'hF, mem_addr=32'h8000_1000, mem_wdata=32'hDEAD_BEEF; tx byte 06.
- Read: bytes 5 F, 04 00 00 80; responder returns mem_rdata=32'h1234_5678 → one-cycle mem_rmask=4'hF at 32'h8000_0004; tx bytes 06 78 56 34 12 in order, never pulsing while tx_busy=1.
- Timeout: read frame with no mem_resp; TIMEOUT_CYCLES=16 → tx byte 15 after 16 WAIT cycles; back in IDLE; a following valid frame completes normally.
- Bad frames:
  - CMD 8'h3F → single NAK 15, nothing on mem_*.
  - CMD 8'hA0 + 8 bytes → NAK, no mem_wmask pulse.
- Interference and reset: rx strobes injected during WAIT/RESP are dropped with no state change; rst_n asserted in WAIT → all outputs 0 next edge, busy=0, no tx pulse.
- With UART_DBG_CHECKSUM_EN: write frame plus correct XOR → ACK; same frame with the checksum bit 0 flipped → NAK, no request.
